seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_decoder.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan decoder
// Purpose: segment pattern table (active-low, bit0=A .. bit6=G), error nibble,
//          segment bit positions and the per-digit working-buffer entry type.
// Ports:   none (package)
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'h40;
  localparam logic [6:0] SEG_PAT_1 = 7'h79;
  localparam logic [6:0] SEG_PAT_2 = 7'h24;
  localparam logic [6:0] SEG_PAT_3 = 7'h30;
  localparam logic [6:0] SEG_PAT_4 = 7'h19;
  localparam logic [6:0] SEG_PAT_5 = 7'h12;
  localparam logic [6:0] SEG_PAT_6 = 7'h02;
  localparam logic [6:0] SEG_PAT_7 = 7'h78;
  localparam logic [6:0] SEG_PAT_8 = 7'h00;
  localparam logic [6:0] SEG_PAT_9 = 7'h10;

  localparam logic [3:0] ERR_NIBBLE = 4'hF;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  typedef struct packed {
    logic       err;
    logic       dp;
    logic [3:0] bcd;
  } seg7_digit_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to BCD lookup
// Purpose: map an active-low A..G pattern to a decimal digit; unknown patterns
//          give the error nibble with o_err set.
// Ports:   i_seg   [6:0] active-low segments A..G
//          o_digit [3:0] decoded digit or ERR_NIBBLE
//          o_err         1 = pattern not in table
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_err
);

  always_comb begin
    o_digit = ERR_NIBBLE;
    o_err   = 1'b1;
    case (i_seg)
      SEG_PAT_0: begin o_digit = 4'd0; o_err = 1'b0; end
      SEG_PAT_1: begin o_digit = 4'd1; o_err = 1'b0; end
      SEG_PAT_2: begin o_digit = 4'd2; o_err = 1'b0; end
      SEG_PAT_3: begin o_digit = 4'd3; o_err = 1'b0; end
      SEG_PAT_4: begin o_digit = 4'd4; o_err = 1'b0; end
      SEG_PAT_5: begin o_digit = 4'd5; o_err = 1'b0; end
      SEG_PAT_6: begin o_digit = 4'd6; o_err = 1'b0; end
      SEG_PAT_7: begin o_digit = 4'd7; o_err = 1'b0; end
      SEG_PAT_8: begin o_digit = 4'd8; o_err = 1'b0; end
      SEG_PAT_9: begin o_digit = 4'd9; o_err = 1'b0; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - snoops a multiplexed 7-segment display and rebuilds frames
// Purpose: synchronize the segment/strobe buses, wait for a settled dwell on a
//          single digit, decode it into a working buffer and publish a full
//          frame with a valid/ready handshake.
// Ports:   clk, rst_n (async active-low)
//          seg_in   [7:0]            active-low segments A..G, bit7 = DP
//          dig_en_n [NUM_DIGITS-1:0] active-low digit strobes
//          bcd_out  [4*NUM_DIGITS-1:0], dp_out, err_out - published frame
//          out_valid / out_ready      frame handshake
//          overrun                    pulse when an unaccepted frame is replaced
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en_n,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   dp_out,
  output logic [NUM_DIGITS-1:0]   err_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);

  localparam logic [7:0] CNT_MAX = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] CNT_CAP = 8'(SETTLE_CYC - 2);

  logic [7:0]            r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0] r_dig_s1, r_dig_s2, r_dig_prev;
  logic [7:0]            r_cnt;
  logic [NUM_DIGITS-1:0] r_mask;
  seg7_digit_t           r_wbuf [NUM_DIGITS];

  logic                  w_changed;
  logic [NUM_DIGITS-1:0] w_dig_act;
  logic                  w_one_low;
  logic                  w_capture;
  logic                  w_frame_done;
  logic [3:0]            w_digit;
  logic                  w_err;

  seg7_pattern_decode u_decode (
    .i_seg   (r_seg_s2[SEG_G_BIT:SEG_A_BIT]),
    .o_digit (w_digit),
    .o_err   (w_err)
  );

  assign w_changed    = (r_seg_s2 != r_seg_prev) || (r_dig_s2 != r_dig_prev);
  assign w_dig_act    = ~r_dig_s2;
  // exactly one strobe active: non-zero and a power of two
  assign w_one_low    = (w_dig_act != '0) &&
                        ((w_dig_act & (w_dig_act - NUM_DIGITS'(1))) == '0);
  // the counter steps from SETTLE_CYC-2 to SETTLE_CYC-1 only once per dwell,
  // since it saturates at SETTLE_CYC-1 until the next input change
  assign w_capture    = !w_changed && (r_cnt == CNT_CAP) && w_one_low;
  assign w_frame_done = &r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_dig_s1   <= '1;
      r_dig_s2   <= '1;
      r_dig_prev <= '1;
      r_cnt      <= '0;
      r_mask     <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_wbuf[i] <= '0;
      bcd_out    <= '0;
      dp_out     <= '0;
      err_out    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_dig_s1   <= dig_en_n;
      r_dig_s2   <= r_dig_s1;
      r_dig_prev <= r_dig_s2;

      if (w_changed)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + 8'd1;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_dig_act[i]) begin
          r_wbuf[i].bcd <= w_digit;
          r_wbuf[i].err <= w_err;
          r_wbuf[i].dp  <= ~r_seg_s2[SEG_DP_BIT];
        end
      end
      r_mask <= (w_frame_done ? '0 : r_mask) | (w_capture ? w_dig_act : '0);

      overrun <= 1'b0;
      if (w_frame_done) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          bcd_out[4*i +: 4] <= r_wbuf[i].bcd;
          dp_out[i]         <= r_wbuf[i].dp;
          err_out[i]        <= r_wbuf[i].err;
        end
        out_valid <= 1'b1;
        // replacing a frame the consumer has not taken this cycle
        overrun   <= out_valid && !out_ready;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
